// File: rtl/membus_arbiter.sv
// membus_arbiter
//
// Shares one memory-bus slave port between the core's instruction-fetch port
// and its data port. One transaction is in flight at a time. When both ports
// request together, the winner is chosen round-robin (FIXED_PRIO = 0) or the
// data port always wins (FIXED_PRIO = 1).
//
// Protocol on every port: the requester raises req and holds addr/we/be/wdata
// stable until it sees a one-cycle valid pulse. If req is still high in the
// cycle after valid, that is a new transaction. An IDLE cycle always follows a
// response, so a new grant is never made in the same cycle as a response.
//
// Optional feature, enabled by defining MEMBUS_ARB_TIMEOUT_EN:
//   A response watchdog. If the slave has not answered by BUSY cycle
//   TIMEOUT_CYCLES, the granted port receives a valid pulse with read data
//   32'hDEADBEEF, err_flag sets and err_addr records the granted address.
//   Without the macro, BUSY waits indefinitely and err_flag/err_addr read 0.
//
// Parameters:
//   FIXED_PRIO     0 = round-robin, 1 = data port wins contention
//   TIMEOUT_CYCLES watchdog limit in clk cycles (2..65535), used only with
//                  the watchdog
//
// Ports:
//   clk, resn                  clock, synchronous active-low reset
//   i_req/i_addr               instruction request and address
//   i_valid/i_rdata            instruction response pulse and read data
//   d_req/d_we/d_be/d_addr/d_wdata  data request and attributes
//   d_valid/d_rdata            data response pulse and read data
//   m_req/m_we/m_be/m_addr/m_wdata  slave request and attributes
//   m_valid/m_rdata            slave response pulse and read data
//   owner                      00 none, 01 instruction, 10 data
//   err_flag/err_addr/err_clr  sticky timeout flag, address of the timed-out
//                              access, and flag clear

module membus_arbiter #(
    parameter int unsigned FIXED_PRIO     = 0,
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic        clk,
    input  logic        resn,

    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic        i_valid,
    output logic [31:0] i_rdata,

    input  logic        d_req,
    input  logic        d_we,
    input  logic [3:0]  d_be,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_valid,
    output logic [31:0] d_rdata,

    output logic        m_req,
    output logic        m_we,
    output logic [3:0]  m_be,
    output logic [31:0] m_addr,
    output logic [31:0] m_wdata,
    input  logic        m_valid,
    input  logic [31:0] m_rdata,

    output logic [1:0]  owner,
    output logic        err_flag,
    output logic [31:0] err_addr,
    input  logic        err_clr
);

    typedef enum logic [1:0] {
        StIdle  = 2'b00,
        StBusyI = 2'b01,
        StBusyD = 2'b10
    } state_e;

    localparam logic [31:0] TimeoutData = 32'hDEAD_BEEF;

    state_e state_q, state_d;
    // Set when the data port won the most recent grant; reset means the
    // instruction port won last, so data wins the first contention.
    logic   last_d_q, last_d_d;
    // Watchdog expiry in the current cycle; constant 0 without the watchdog.
    logic   timeout;

    // ------------------------------------------------------------------
    // Arbitration, bus muxing and response routing
    // ------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        last_d_d = last_d_q;

        m_req    = 1'b0;
        m_we     = 1'b0;
        m_be     = 4'b0000;
        m_addr   = 32'h0;
        m_wdata  = 32'h0;
        owner    = 2'b00;

        i_valid  = 1'b0;
        d_valid  = 1'b0;
        i_rdata  = m_rdata;
        d_rdata  = m_rdata;

        case (state_q)
            StIdle: begin
                // A response seen here is stale or stray and is dropped.
                if (i_req && d_req) begin
                    if ((FIXED_PRIO != 0) || !last_d_q) begin
                        state_d  = StBusyD;
                        last_d_d = 1'b1;
                    end else begin
                        state_d  = StBusyI;
                        last_d_d = 1'b0;
                    end
                end else if (d_req) begin
                    state_d  = StBusyD;
                    last_d_d = 1'b1;
                end else if (i_req) begin
                    state_d  = StBusyI;
                    last_d_d = 1'b0;
                end
            end

            StBusyI: begin
                // Fetches are reads; write attributes stay at zero.
                owner  = 2'b01;
                m_req  = i_req;
                m_addr = i_addr;
                if (m_valid || timeout) begin
                    i_valid = 1'b1;
                    state_d = StIdle;
                end
                if (timeout) begin
                    i_rdata = TimeoutData;
                end
            end

            StBusyD: begin
                owner   = 2'b10;
                m_req   = d_req;
                m_we    = d_we;
                m_be    = d_be;
                m_addr  = d_addr;
                m_wdata = d_wdata;
                if (m_valid || timeout) begin
                    d_valid = 1'b1;
                    state_d = StIdle;
                end
                if (timeout) begin
                    d_rdata = TimeoutData;
                end
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resn) begin
            state_q  <= StIdle;
            last_d_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            last_d_q <= last_d_d;
        end
    end

    // ------------------------------------------------------------------
    // Response watchdog
    // ------------------------------------------------------------------
`ifdef MEMBUS_ARB_TIMEOUT_EN
    localparam logic [15:0] TimeoutLast = 16'(TIMEOUT_CYCLES - 1);

    logic [15:0] wd_cnt_q, wd_cnt_d;
    logic        err_flag_q, err_flag_d;
    logic [31:0] err_addr_q, err_addr_d;

    // Expiry needs no m_valid in the same cycle: a real response wins.
    assign timeout = (state_q != StIdle) && !m_valid && (wd_cnt_q == TimeoutLast);

    always_comb begin
        // Held at zero while idle, so each grant starts counting from zero.
        wd_cnt_d = 16'h0;
        if (state_q != StIdle) begin
            wd_cnt_d = wd_cnt_q + 16'h1;
        end

        err_flag_d = err_flag_q;
        err_addr_d = err_addr_q;
        if (timeout) begin
            // A fresh timeout outranks a clear in the same cycle.
            err_flag_d = 1'b1;
            err_addr_d = m_addr;
        end else if (err_clr) begin
            err_flag_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!resn) begin
            wd_cnt_q   <= 16'h0;
            err_flag_q <= 1'b0;
            err_addr_q <= 32'h0;
        end else begin
            wd_cnt_q   <= wd_cnt_d;
            err_flag_q <= err_flag_d;
            err_addr_q <= err_addr_d;
        end
    end

    assign err_flag = err_flag_q;
    assign err_addr = err_addr_q;
`else
    assign timeout  = 1'b0;
    assign err_flag = 1'b0;
    assign err_addr = 32'h0;

    // Without the watchdog the clear input and the limit have no function.
    logic [16:0] unused_wd;
    assign unused_wd = {err_clr, 16'(TIMEOUT_CYCLES)};
`endif

endmodule

// File: tb/tb_membus_arbiter.sv
// Bench for membus_arbiter: directed cases with literal expectations, then a
// long randomized run. A transaction-level model of the arbiter is compared
// against every DUT output on every falling edge.

module tb_membus_arbiter;

    localparam int unsigned TO = 8;

    logic        clk = 1'b0;
    logic        resn = 1'b0;

    logic        i_req = 1'b0;
    logic [31:0] i_addr = '0;
    logic        i_valid;
    logic [31:0] i_rdata;
    logic        d_req = 1'b0;
    logic        d_we = 1'b0;
    logic [3:0]  d_be = '0;
    logic [31:0] d_addr = '0;
    logic [31:0] d_wdata = '0;
    logic        d_valid;
    logic [31:0] d_rdata;
    logic        m_req;
    logic        m_we;
    logic [3:0]  m_be;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic        m_valid = 1'b0;
    logic [31:0] m_rdata = '0;
    logic [1:0]  owner;
    logic        err_flag;
    logic [31:0] err_addr;
    logic        err_clr = 1'b0;

    // Second instance, fixed priority, driven only in its own phase.
    logic        f_i_req = 1'b0;
    logic        f_d_req = 1'b0;
    logic        f_m_valid = 1'b0;
    logic        f_i_valid, f_d_valid, f_m_req, f_m_we, f_err_flag;
    logic [31:0] f_i_rdata, f_d_rdata, f_m_addr, f_m_wdata, f_err_addr;
    logic [3:0]  f_m_be;
    logic [1:0]  f_owner;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    membus_arbiter #(
        .FIXED_PRIO    (0),
        .TIMEOUT_CYCLES(TO)
    ) u_dut (
        .clk     (clk),
        .resn    (resn),
        .i_req   (i_req),
        .i_addr  (i_addr),
        .i_valid (i_valid),
        .i_rdata (i_rdata),
        .d_req   (d_req),
        .d_we    (d_we),
        .d_be    (d_be),
        .d_addr  (d_addr),
        .d_wdata (d_wdata),
        .d_valid (d_valid),
        .d_rdata (d_rdata),
        .m_req   (m_req),
        .m_we    (m_we),
        .m_be    (m_be),
        .m_addr  (m_addr),
        .m_wdata (m_wdata),
        .m_valid (m_valid),
        .m_rdata (m_rdata),
        .owner   (owner),
        .err_flag(err_flag),
        .err_addr(err_addr),
        .err_clr (err_clr)
    );

    membus_arbiter #(
        .FIXED_PRIO    (1),
        .TIMEOUT_CYCLES(TO)
    ) u_fix (
        .clk     (clk),
        .resn    (resn),
        .i_req   (f_i_req),
        .i_addr  (32'h0000_0500),
        .i_valid (f_i_valid),
        .i_rdata (f_i_rdata),
        .d_req   (f_d_req),
        .d_we    (1'b0),
        .d_be    (4'hF),
        .d_addr  (32'h0000_0600),
        .d_wdata (32'h0),
        .d_valid (f_d_valid),
        .d_rdata (f_d_rdata),
        .m_req   (f_m_req),
        .m_we    (f_m_we),
        .m_be    (f_m_be),
        .m_addr  (f_m_addr),
        .m_wdata (f_m_wdata),
        .m_valid (f_m_valid),
        .m_rdata (32'h1234_5678),
        .owner   (f_owner),
        .err_flag(f_err_flag),
        .err_addr(f_err_addr),
        .err_clr (1'b0)
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, got, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: who holds the bus (0 none, 1 instr, 2 data), who won
    // last, how many BUSY cycles have elapsed, and the error record.
    // ------------------------------------------------------------------
    int          mdl_owner = 0;
    int          mdl_last = 1;
    int          mdl_cnt = 0;
    logic        mdl_err = 1'b0;
    logic [31:0] mdl_err_addr = '0;
    bit          mdl_live = 1'b0;

    function automatic bit mdl_timeout();
`ifdef MEMBUS_ARB_TIMEOUT_EN
        return (mdl_owner != 0) && !m_valid && (mdl_cnt == int'(TO) - 1);
`else
        return 1'b0;
`endif
    endfunction

    always @(posedge clk) begin
        bit to;
        if (!resn) begin
            mdl_owner    = 0;
            mdl_last     = 1;
            mdl_cnt      = 0;
            mdl_err      = 1'b0;
            mdl_err_addr = '0;
            mdl_live     = 1'b1;
        end else if (mdl_live) begin
            to = mdl_timeout();
            if (to) begin
                mdl_err      = 1'b1;
                mdl_err_addr = (mdl_owner == 1) ? i_addr : d_addr;
            end else if (err_clr) begin
                mdl_err = 1'b0;
            end
            if (mdl_owner == 0) begin
                if (i_req && d_req) mdl_owner = (mdl_last == 1) ? 2 : 1;
                else if (d_req)     mdl_owner = 2;
                else if (i_req)     mdl_owner = 1;
                if (mdl_owner != 0) begin
                    mdl_last = mdl_owner;
                    mdl_cnt  = 0;
                end
            end else if (m_valid || to) begin
                mdl_owner = 0;
            end else begin
                mdl_cnt++;
            end
        end
    end

    always @(negedge clk) begin
        bit          to;
        logic        e_req, e_we;
        logic [3:0]  e_be;
        logic [31:0] e_addr, e_wdata;
        if (mdl_live) begin
            to      = mdl_timeout();
            e_req   = 1'b0;
            e_we    = 1'b0;
            e_be    = 4'h0;
            e_addr  = '0;
            e_wdata = '0;
            if (mdl_owner == 1) begin
                e_req  = i_req;
                e_addr = i_addr;
            end else if (mdl_owner == 2) begin
                e_req   = d_req;
                e_we    = d_we;
                e_be    = d_be;
                e_addr  = d_addr;
                e_wdata = d_wdata;
            end
            check("owner", {30'b0, owner}, 32'(mdl_owner));
            check("m_req", m_req, e_req);
            check("m_we", m_we, e_we);
            check("m_be", m_be, e_be);
            check("m_addr", m_addr, e_addr);
            check("m_wdata", m_wdata, e_wdata);
            check("i_valid", i_valid, (mdl_owner == 1) && (m_valid || to));
            check("d_valid", d_valid, (mdl_owner == 2) && (m_valid || to));
            check("i_rdata", i_rdata, (to && mdl_owner == 1) ? 32'hDEAD_BEEF : m_rdata);
            check("d_rdata", d_rdata, (to && mdl_owner == 2) ? 32'hDEAD_BEEF : m_rdata);
            check("err_flag", err_flag, mdl_err);
            check("err_addr", err_addr, mdl_err_addr);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ------------------------------------------------------------------
    // Stimulus with literal expectations
    // ------------------------------------------------------------------
    int   sl_cnt;
    logic iv_seen, dv_seen;

    initial begin
        // Reset
        tick();
        tick();
        resn = 1'b1;
        #1;
        check("rst_owner", owner, 2'b00);
        check("rst_m_req", m_req, 1'b0);
        check("rst_err", err_flag, 1'b0);

        // Single instruction read, slave answers two cycles after m_req
        tick();
        i_req  = 1'b1;
        i_addr = 32'h0000_0100;
        #1;
        check("ird_arb_cycle_m_req", m_req, 1'b0);
        tick();
        #1;
        check("ird_owner", owner, 2'b01);
        check("ird_m_req", m_req, 1'b1);
        check("ird_m_addr", m_addr, 32'h0000_0100);
        check("ird_m_we", m_we, 1'b0);
        check("ird_m_be", m_be, 4'b0000);
        tick();
        tick();
        m_valid = 1'b1;
        m_rdata = 32'h0000_0013;
        #1;
        check("ird_i_valid", i_valid, 1'b1);
        check("ird_i_rdata", i_rdata, 32'h0000_0013);
        check("ird_d_valid", d_valid, 1'b0);
        tick();
        m_valid = 1'b0;
        i_req   = 1'b0;
        #1;
        check("ird_owner_after", owner, 2'b00);
        check("ird_i_valid_after", i_valid, 1'b0);

        // Data write passthrough
        tick();
        d_req   = 1'b1;
        d_we    = 1'b1;
        d_be    = 4'b0011;
        d_addr  = 32'h2000_0004;
        d_wdata = 32'hCAFE_BABE;
        tick();
        #1;
        check("dwr_owner", owner, 2'b10);
        check("dwr_m_we", m_we, 1'b1);
        check("dwr_m_be", m_be, 4'b0011);
        check("dwr_m_addr", m_addr, 32'h2000_0004);
        check("dwr_m_wdata", m_wdata, 32'hCAFE_BABE);
        tick();
        m_valid = 1'b1;
        m_rdata = 32'h0;
        #1;
        check("dwr_d_valid", d_valid, 1'b1);
        check("dwr_i_valid", i_valid, 1'b0);
        tick();
        m_valid = 1'b0;
        d_req   = 1'b0;
        d_we    = 1'b0;

        // Reset in the middle of a data transaction drops its response
        tick();
        d_req  = 1'b1;
        d_addr = 32'h0000_0300;
        d_be   = 4'hF;
        tick();
        #1;
        check("rmid_owner", owner, 2'b10);
        tick();
        resn = 1'b0;
        tick();
        resn    = 1'b1;
        d_req   = 1'b0;
        m_valid = 1'b1;
        m_rdata = 32'h0000_0055;
        #1;
        check("rmid_d_valid", d_valid, 1'b0);
        check("rmid_m_req", m_req, 1'b0);
        check("rmid_owner_after", owner, 2'b00);
        tick();
        m_valid = 1'b0;

        // Round-robin contention from reset state: D, I, D, I
        tick();
        i_req  = 1'b1;
        d_req  = 1'b1;
        i_addr = 32'h0000_0111;
        d_addr = 32'h0000_0222;
        for (int t = 0; t < 4; t++) begin
            tick();
            #1;
            check("rr_grant", owner, (t % 2 == 0) ? 2'b10 : 2'b01);
            tick();
            m_valid = 1'b1;
            m_rdata = 32'(t);
            #1;
            if (t % 2 == 0) check("rr_d_valid", d_valid, 1'b1);
            else            check("rr_i_valid", i_valid, 1'b1);
            check("rr_no_both_valid", i_valid & d_valid, 1'b0);
            tick();
            m_valid = 1'b0;
        end
        i_req = 1'b0;
        d_req = 1'b0;

        // Unanswered data access, slave never responds
        tick();
        d_req  = 1'b1;
        d_addr = 32'h0000_0040;
        for (int k = 1; k <= int'(TO); k++) begin
            tick();
            #1;
`ifdef MEMBUS_ARB_TIMEOUT_EN
            if (k < int'(TO)) begin
                check("to_early_d_valid", d_valid, 1'b0);
            end else begin
                check("to_d_valid", d_valid, 1'b1);
                check("to_d_rdata", d_rdata, 32'hDEAD_BEEF);
            end
`else
            check("nto_d_valid", d_valid, 1'b0);
`endif
        end
`ifdef MEMBUS_ARB_TIMEOUT_EN
        tick();
        d_req = 1'b0;
        #1;
        check("to_err_flag", err_flag, 1'b1);
        check("to_err_addr", err_addr, 32'h0000_0040);
        check("to_owner", owner, 2'b00);
        tick();
        err_clr = 1'b1;
        #1;
        check("to_err_held", err_flag, 1'b1);
        tick();
        err_clr = 1'b0;
        #1;
        check("to_err_cleared", err_flag, 1'b0);
`else
        tick();
        m_valid = 1'b1;
        #1;
        check("nto_late_d_valid", d_valid, 1'b1);
        check("nto_err_flag", err_flag, 1'b0);
        tick();
        m_valid = 1'b0;
        d_req   = 1'b0;
`endif

        // Fixed priority instance: data wins every contention
        tick();
        f_i_req = 1'b1;
        f_d_req = 1'b1;
        for (int t = 0; t < 4; t++) begin
            tick();
            #1;
            check("fp_grant", f_owner, 2'b10);
            check("fp_m_addr", f_m_addr, 32'h0000_0600);
            tick();
            f_m_valid = 1'b1;
            #1;
            check("fp_d_valid", f_d_valid, 1'b1);
            check("fp_i_valid", f_i_valid, 1'b0);
            tick();
            f_m_valid = 1'b0;
            #1;
            check("fp_i_valid_idle", f_i_valid, 1'b0);
        end
        f_i_req = 1'b0;
        f_d_req = 1'b0;

        // Randomized traffic with a variable-latency slave and stray responses
        sl_cnt  = 0;
        iv_seen = 1'b0;
        dv_seen = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            tick();
            if (i_req && iv_seen) begin
                i_req  = ($urandom_range(0, 1) == 1);
                i_addr = $urandom;
            end else if (!i_req && $urandom_range(0, 2) == 0) begin
                i_req  = 1'b1;
                i_addr = $urandom;
            end
            if (d_req && dv_seen) begin
                d_req   = ($urandom_range(0, 1) == 1);
                d_we    = ($urandom_range(0, 1) == 1);
                d_be    = 4'($urandom);
                d_addr  = $urandom;
                d_wdata = $urandom;
            end else if (!d_req && $urandom_range(0, 2) == 0) begin
                d_req   = 1'b1;
                d_we    = ($urandom_range(0, 1) == 1);
                d_be    = 4'($urandom);
                d_addr  = $urandom;
                d_wdata = $urandom;
            end
            err_clr = ($urandom_range(0, 15) == 0);
            #1;
            m_valid = 1'b0;
            m_rdata = $urandom;
            if (sl_cnt > 0) begin
                sl_cnt--;
                if (sl_cnt == 0) m_valid = 1'b1;
            end else if (m_req) begin
                sl_cnt = $urandom_range(1, 10);
            end else if ($urandom_range(0, 15) == 0) begin
                m_valid = 1'b1;
            end
            #2;
            iv_seen = i_valid;
            dv_seen = d_valid;
        end
        tick();
        i_req   = 1'b0;
        d_req   = 1'b0;
        m_valid = 1'b0;
        err_clr = 1'b0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/membus_arbiter.md
Name: membus_arbiter

Overview:
- Shares one SoC memory-bus slave port between the core's instruction-fetch port and data port, for unified single-port memory configurations.
- Sits between the core-side fanout signals (instruction port: req/valid/addr/rdata; data port: req/valid/we/be/addr/wdata/rdata) and the SoC slave bus.
- Serialises transactions one at a time, with round-robin or fixed data-first priority.
- Optionally guards against hung slaves with a response watchdog.

Parameters:
- FIXED_PRIO, 0: 0 = round-robin between ports; 1 = data port always wins when both request.
- TIMEOUT_CYCLES, 256: watchdog limit in clk cycles, measured from slave req assertion. Only used with the optional feature. Legal range 2..65535.

Ports:
- clk  input  1  single system clock (core clock domain).
- resn  input  1  reset: synchronous, active-low.
- i_req  input  1  instruction request.
- i_addr  input  32  instruction address.
- i_valid  output  1  instruction response pulse.
- i_rdata  output  32  instruction read data.
- d_req  input  1  data request.
- d_we  input  1  data write enable.
- d_be  input  4  data byte enables.
- d_addr  input  32  data address.
- d_wdata  input  32  data write data.
- d_valid  output  1  data response pulse.
- d_rdata  output  32  data read data.
- m_req  output  1  slave request.
- m_we  output  1  slave write enable.
- m_be  output  4  slave byte enables.
- m_addr  output  32  slave address.
- m_wdata  output  32  slave write data.
- m_valid  input  1  slave response pulse.
- m_rdata  input  32  slave read data.
- owner  output  2  current owner: 00 none, 01 instruction, 10 data.
- err_flag  output  1  sticky timeout error (optional feature).
- err_addr  output  32  address of the timed-out access (optional feature).
- err_clr  input  1  clears err_flag.

Behaviour:
- Bus protocol, all ports: a requester raises req and holds addr/we/be/wdata stable until it sees valid, a single-cycle pulse. req still high in the cycle after valid means a new transaction.
- States: IDLE, BUSY_I, BUSY_D.
- IDLE, neither req: stay in IDLE.
- IDLE, one req: move to BUSY of that port.
- IDLE, both req, FIXED_PRIO=1: move to BUSY_D.
- IDLE, both req, FIXED_PRIO=0: grant the port that did NOT win the last grant. last_grant resets to instruction, so data wins the first contention.
- BUSY_x: m_req = x_req, and slave address/control are muxed combinationally from port x.
- Instruction grant forces m_we=0, m_be=4'b0000, m_wdata=0.
- BUSY_x on m_valid: x_valid=1 in the same cycle, x_rdata=m_rdata, next state IDLE.
- Other port's valid is never asserted during BUSY_x.
- IDLE outputs: m_req/m_we=0, m_be=0, m_addr/m_wdata=0, owner=00.
- i_rdata and d_rdata always carry m_rdata. Requesters qualify it with valid.
- Latency: at least 1 arbitration cycle. Request seen in cycle N gives m_req in N+1. Response forwarded with zero added latency.
- Back-to-back: maximum throughput is one transaction per 2 + slave-latency cycles, because an IDLE bubble always follows valid.
- m_valid while in IDLE, including stale responses: ignored, no valid forwarded.
- Requester drops req before valid (protocol violation): m_req follows to 0. The arbiter stays BUSY until m_valid or timeout.
- Reset (resn=0 at a rising edge): state=IDLE, last_grant=instruction, all outputs listed above zero from the next cycle. err_flag=0, err_addr=0, watchdog counter=0.
- Reset mid-transaction: the outstanding slave response is dropped.

Optional Feature:
- Macro: MEMBUS_ARB_TIMEOUT_EN.
- Enabled, counter: a 16-bit counter clears on entering BUSY_x and increments each BUSY cycle.
- Enabled, timeout: if it reaches TIMEOUT_CYCLES-1 with no m_valid, then:
  - x_valid pulses with x_rdata=32'hDEADBEEF;
  - err_flag sets;
  - err_addr latches the granted address;
  - next state is IDLE.
- Enabled, simultaneous m_valid in the timeout cycle: m_valid wins, no error.
- err_clr=1 clears err_flag next cycle. A new timeout in the same cycle as err_clr wins, so err_flag stays 1.
- Disabled: no counter logic; BUSY waits indefinitely; err_flag and err_addr tied 0; err_clr ignored.

Test Plan:
- Single instruction read: i_req=1, i_addr=0x100, slave answers 2 cycles after m_req with 0x00000013 -> m_req in cycle+1 with m_we=0, m_be=0; i_valid one cycle with i_rdata=0x13; owner 01 then 00.
- Contention, round-robin: i_req and d_req held high from reset, slave 1-cycle latency -> grant order D, I, D, I; d_valid and i_valid never in the same cycle.
- Contention, FIXED_PRIO=1: both held high for 4 transactions -> all 4 grants go to data, no i_valid.
- Data write passthrough: d_we=1, d_be=4'b0011, d_addr=0x2000_0004, d_wdata=0xCAFEBABE -> identical values on m_*; d_valid on m_valid.
- Reset mid-transaction: resn low for one cycle while BUSY_D, then slave sends m_valid -> no d_valid; m_req=0 after reset.
- Timeout (macro on, TIMEOUT_CYCLES=8): slave never answers d_addr=0x40 -> d_valid at cycle 8 of BUSY with 0xDEADBEEF; err_flag=1, err_addr=0x40; err_clr -> err_flag=0.
